cereal_rx: RTL and testbench

CEREAL_RX -- requirements
Module: cereal_rx

---
 rtl/cereal_rx.sv | 135 +++++++++++++
 tb/tb_cereal_rx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cereal_rx.sv
// 8N1 serial receiver: 2-flop synchronizer, mid-bit sampling FSM, single-entry
// output register with valid/ack handshake, frame error pulse and sticky overrun.
module cereal_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 15
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       cereal,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(CLKS_PER_BIT - 1);

  state_t           r_state, w_state_next;
  logic             r_sync1, r_sync2;
  logic             w_rx_s;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [2:0]       r_idx, w_idx_next;
  logic [7:0]       r_shift, w_shift_next;
  logic [7:0]       r_data;
  logic             r_valid, r_ferr, r_overrun;
  logic             w_stop_good, w_stop_bad, w_deliver;

  assign w_rx_s = r_sync2;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_stop_good  = 1'b0;
    w_stop_bad   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_next = S_START;
          w_cnt_next   = '0;
        end
      end
      S_START: begin
        if (r_cnt == C_HALF) begin
          w_cnt_next   = '0;
          w_idx_next   = 3'd0;
          // A line that is high again at mid start bit was only a glitch.
          w_state_next = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == C_FULL) begin
          w_cnt_next          = '0;
          w_shift_next[r_idx] = w_rx_s;
          w_idx_next          = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_next = S_STOP;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (r_cnt == C_FULL) begin
          w_cnt_next = '0;
          if (w_rx_s) begin
            w_stop_good  = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_stop_bad   = 1'b1;
            w_state_next = S_WAIT_HIGH;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (w_rx_s) w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
        w_idx_next   = 3'd0;
      end
    endcase
  end

  // An ack in the delivery cycle frees the output register for the new byte.
  assign w_deliver = w_stop_good && (!r_valid || ack);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= 3'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_sync1   <= cereal;
      r_sync2   <= r_sync1;
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_idx     <= w_idx_next;
      r_shift   <= w_shift_next;
      if (w_deliver) r_data <= r_shift;
      r_valid   <= w_deliver | (r_valid & ~ack);
      r_ferr    <= w_stop_bad;
      r_overrun <= ack ? 1'b0 : (r_overrun | (w_stop_good & ~w_deliver));
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_cereal_rx.sv
// Self-checking bench for cereal_rx at 16 clocks per bit; received bytes are
// checked against a scoreboard queue filled as frames are driven.
module tb_cereal_rx;
  localparam int CPB = 16;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       cereal = 1'b1;
  logic       ack    = 1'b0;
  logic [7:0] data;
  logic       valid, busy, frame_err, overrun;

  int checks = 0;
  int errors = 0;
  int ferr_cycles = 0;
  logic [7:0] exp_q[$];

  always #5 sysclk = ~sysclk;

  cereal_rx #(.CLKS_PER_BIT(CPB), .CNT_W(15)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .cereal(cereal), .data(data),
    .valid(valid), .ack(ack), .busy(busy), .frame_err(frame_err),
    .overrun(overrun)
  );

  always @(negedge sysclk) if (frame_err === 1'b1) ferr_cycles++;

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Drives one frame; the line is left at stop_val afterwards.
  task automatic send_byte(input logic [7:0] b, input int stop_cycles,
                           input logic stop_val, input bit ack_in_stop);
    cereal = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      cereal = b[i];
      tick(CPB);
    end
    cereal = stop_val;
    for (int i = 0; i < stop_cycles; i++) begin
      if (ack_in_stop) ack = busy;
      tick(1);
    end
    if (ack_in_stop) ack = 1'b0;
    $display("sent byte %h stop=%0b", b, stop_val);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++;
    if ({data, valid, busy, frame_err, overrun} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h v=%b b=%b fe=%b ov=%b, expected all 0",
               data, valid, busy, frame_err, overrun);
    end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_good_byte();
    bit ok;
    logic [7:0] exp;
    int fe0 = ferr_cycles;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, CPB, 1'b1, 1'b0);
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL a5_valid: got valid=%b, expected 1", valid);
    end
    exp = exp_q.pop_front();
    checks++;
    if (data !== exp) begin
      errors++;
      $display("FAIL a5_data: got %h, expected %h", data, exp);
    end
    checks++;
    if (ferr_cycles !== fe0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL a5_flags: got ferr_cycles=%0d busy=%b, expected %0d busy=0",
               ferr_cycles, busy, fe0);
    end
    $display("rx byte %h", data);
    pulse_ack();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL a5_ack: got valid=%b, expected 0", valid);
    end
  endtask

  task automatic test_glitch();
    bit saw_busy = 1'b0;
    int fe0 = ferr_cycles;
    cereal = 1'b0;
    tick(4);
    cereal = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b1) saw_busy = 1'b1;
      tick(1);
    end
    checks++;
    if (!saw_busy || busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy: got saw_busy=%b busy=%b, expected 1 then 0", saw_busy, busy);
    end
    checks++;
    if (valid !== 1'b0 || ferr_cycles !== fe0) begin
      errors++;
      $display("FAIL glitch_flags: got valid=%b ferr_cycles=%0d, expected 0 and %0d",
               valid, ferr_cycles, fe0);
    end
  endtask

  task automatic test_frame_err();
    bit ok;
    logic [7:0] exp;
    int fe0 = ferr_cycles;
    send_byte(8'h3C, 40, 1'b0, 1'b0);
    checks++;
    if (ferr_cycles !== fe0 + 1) begin
      errors++;
      $display("FAIL ferr_pulse: got %0d cycles high, expected 1", ferr_cycles - fe0);
    end
    checks++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ferr_wait_high: got valid=%b busy=%b, expected 0 and 1", valid, busy);
    end
    cereal = 1'b1;
    tick(5);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ferr_idle: got busy=%b, expected 0", busy);
    end
    exp_q.push_back(8'h81);
    send_byte(8'h81, CPB, 1'b1, 1'b0);
    wait_valid(ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || data !== exp) begin
      errors++;
      $display("FAIL ferr_next_byte: got data=%h valid=%b, expected %h valid=1", data, valid, exp);
    end
    $display("rx byte %h", data);
    pulse_ack();
  endtask

  task automatic test_overrun();
    bit ok;
    logic [7:0] exp;
    exp_q.push_back(8'h11);
    send_byte(8'h11, CPB, 1'b1, 1'b0);
    wait_valid(ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || data !== exp) begin
      errors++;
      $display("FAIL ovr_first: got data=%h valid=%b, expected %h valid=1", data, valid, exp);
    end
    $display("rx byte %h", data);
    send_byte(8'h22, CPB, 1'b1, 1'b0);
    checks++;
    if (data !== 8'h11 || overrun !== 1'b1 || valid !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set: got data=%h ov=%b v=%b, expected 11 ov=1 v=1", data, overrun, valid);
    end
    pulse_ack();
    checks++;
    if (valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: got v=%b ov=%b, expected 0 0", valid, overrun);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] exp;
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, CPB, 1'b1, 1'b0);
    wait_valid(ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || data !== exp) begin
      errors++;
      $display("FAIL b2b_first: got data=%h valid=%b, expected %h valid=1", data, valid, exp);
    end
    $display("rx byte %h", data);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, CPB, 1'b1, 1'b1);
    tick(2);
    exp = exp_q.pop_front();
    checks++;
    if (valid !== 1'b1 || data !== exp || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ack_hold: got data=%h v=%b ov=%b, expected %h v=1 ov=0",
               data, valid, overrun, exp);
    end
    $display("rx byte %h", data);
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] exp;
    cereal = 1'b0;
    tick(CPB);
    cereal = 1'b1;
    tick(4 * CPB + CPB / 2);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data, valid, busy, frame_err, overrun} !== 12'h000) begin
      errors++;
      $display("FAIL rst_mid_outputs: got data=%h v=%b b=%b fe=%b ov=%b, expected all 0",
               data, valid, busy, frame_err, overrun);
    end
    tick(3);
    rst_n = 1'b1;
    tick(5);
    exp_q.push_back(8'h00);
    send_byte(8'h00, CPB, 1'b1, 1'b0);
    wait_valid(ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || data !== exp) begin
      errors++;
      $display("FAIL rst_mid_next: got data=%h valid=%b, expected %h valid=1", data, valid, exp);
    end
    $display("rx byte %h", data);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d left, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_good_byte();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
